sdc_reader_data_rx: RTL and testbench
=====================================

# sdc_reader_data_rx

Receive-side counterpart of the SD-card block-write data path. It samples the card's DAT0 line in 1-bit mode after a read command has been issued. It finds the start bit, deserialises one data block MSB-first into bytes, and checks the trailing CRC16 and end bit. It reports each byte and the end-of-block status to the host-side FIFO and controller logic.

## Interface
Parameters:
- BLOCK_BYTES, 512: data bytes per block; sets the data bit count to BLOCK_BYTES*8.
- TIMEOUT, 16'hFFFF: number of bit strobes to wait for a start bit before giving up.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- bitEn  in  1  one-cycle strobe marking the DAT0 sample point of each SD clock period.
- datIn  in  1  DAT0 from the card, already synchronised.
- start  in  1  one-cycle pulse that arms the receiver for one block.
- dataOut  out  8  last assembled byte.
- byteValid  out  1  one-cycle pulse; dataOut is valid for that cycle.
- blockDone  out  1  one-cycle pulse when the block ends, with or without error.
- crcError  out  1  received CRC16 ≠ computed CRC16; sticky.
- endError  out  1  end bit sampled as 0; sticky.
- timeoutError  out  1  no start bit within TIMEOUT strobes; sticky.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WAIT_START, DATA, CRC, END.
- IDLE:
  - start moves to WAIT_START.
  - start clears crcError, endError, timeoutError, the timeout counter, the bit counter and the CRC register (0x0000).
  - bitEn is ignored.
- WAIT_START, on each bitEn:
  - datIn=0 moves to DATA with the bit counter at 0.
  - datIn=1 increments the timeout counter. When the counter reaches TIMEOUT, set timeoutError, pulse blockDone and return to IDLE.
- DATA, on each bitEn:
  - Shift datIn into the byte shift register, MSB first.
  - Update the CRC16-CCITT, polynomial x^16+x^12+x^5+1, init 0: fb = crc[15]^datIn; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - Increment the bit counter, width clog2(BLOCK_BYTES*8).
  - When bit counter[2:0] = 7 on this strobe, register dataOut = {shreg[6:0], datIn} and pulse byteValid.
  - After bit BLOCK_BYTES*8-1, move to CRC with the counter cleared.
- CRC:
  - Shift 16 bits into rxCrc, MSB first, on bitEn.
  - The computed CRC is frozen.
  - After the 16th bit, move to END.
- END, on bitEn:
  - endError = ~datIn.
  - crcError = (rxCrc ≠ crc).
  - Pulse blockDone and return to IDLE.
- Boundary and error behaviour:
  - start while busy is ignored.
  - bitEn held high on consecutive cycles is legal; each cycle is one bit.
  - Reset mid-block aborts immediately: no blockDone, no error flags.
  - Error flags hold until the next accepted start or reset.
  - Multi-bit DAT[3:0] mode, busy signalling and multi-block streaming are out of scope; the controller re-arms with start for each block.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Shift register, rxCrc and crc 0; counters 0.
- busy rises the cycle after start is accepted. It falls the cycle after the END or timeout strobe, together with the blockDone pulse.
- byteValid and dataOut update in the cycle after the bitEn that samples bit 7 of each byte. The pulse lasts one cycle. dataOut holds its value until the next byte.
- The last byteValid precedes blockDone by at least 17 bitEn strobes.
- crcError, endError and timeoutError are valid in the same cycle as blockDone.
- Minimum block length: 1 start + BLOCK_BYTES*8 + 16 + 1 strobes after the first start-bit search strobe.
- Throughput: one bit per cycle maximum, with no back-pressure. The downstream FIFO must accept a byte every 8 bitEn.

## Test plan
- Block of 0xFF with correct CRC:
  - Stimulus: reset, start, 3 idle-1 bits, start bit, 512×0xFF, CRC 0x7FA1, end bit 1.
  - Response: 512 byteValid pulses, each with dataOut=0xFF; one blockDone; crcError=0, endError=0, timeoutError=0; busy=0 afterward.
- Bad CRC: same block but CRC 0x7FA0 → crcError=1 at blockDone; all 512 bytes still delivered.
- Bad end bit: same block with end bit 0 → endError=1, crcError=0.
- Start-bit timeout: start, then datIn held 1 for TIMEOUT strobes → timeoutError=1 with the blockDone pulse, busy=0, zero byteValid. A following start clears timeoutError.
- Reset mid-block: reset asserted after byte 100 → all outputs 0 next cycle, no blockDone. A subsequent full 0xFF block is received correctly with crcError=0.
- Byte order and strobe spacing:
  - Stimulus: bitEn spacing randomised 1–5 cycles; data bytes 0x00..0xFF twice; CRC from the reference model.
  - Response: dataOut sequence matches exactly, MSB first; crcError=0; a start pulse mid-block has no effect.

Source files
------------

// File: rtl/sdc_reader_data_rx_if.sv
// rtl/sdc_reader_data_rx_if.sv - DAT0 receive-side handshake and status bundle
interface sdc_reader_data_rx_if;
  logic       bitEn;
  logic       datIn;
  logic       start;
  logic [7:0] dataOut;
  logic       byteValid;
  logic       blockDone;
  logic       crcError;
  logic       endError;
  logic       timeoutError;
  logic       busy;

  modport master (
    output bitEn, datIn, start,
    input  dataOut, byteValid, blockDone, crcError, endError, timeoutError, busy
  );

  modport slave (
    input  bitEn, datIn, start,
    output dataOut, byteValid, blockDone, crcError, endError, timeoutError, busy
  );
endinterface

// File: rtl/sdc_reader_data_rx.sv
// rtl/sdc_reader_data_rx.sv - SD DAT0 1-bit block receiver with start search, CRC16 and end-bit check
module sdc_reader_data_rx #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned TIMEOUT     = 16'hFFFF
) (
  input logic                clk,
  input logic                reset,
  sdc_reader_data_rx_if.slave bus
);
  localparam int unsigned NBITS = BLOCK_BYTES * 8;
  localparam int          CW    = $clog2(NBITS);
  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(NBITS - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END} state_t;

  state_t        state_q, state_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   rx_crc_q, rx_crc_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          block_done_q, block_done_d;
  logic          crc_err_q, crc_err_d;
  logic          end_err_q, end_err_d;
  logic          tmo_err_q, tmo_err_d;
  logic          fb;
  logic [TW-1:0] tmo_inc;

  assign fb      = crc_q[15] ^ bus.datIn;
  assign tmo_inc = tmo_q + TW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      crc_q        <= '0;
      rx_crc_q     <= '0;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      data_out_q   <= '0;
      byte_valid_q <= 1'b0;
      block_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      end_err_q    <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      crc_q        <= crc_d;
      rx_crc_q     <= rx_crc_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      data_out_q   <= data_out_d;
      byte_valid_q <= byte_valid_d;
      block_done_q <= block_done_d;
      crc_err_q    <= crc_err_d;
      end_err_q    <= end_err_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    crc_d        = crc_q;
    rx_crc_d     = rx_crc_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    data_out_d   = data_out_q;
    byte_valid_d = 1'b0;
    block_done_d = 1'b0;
    crc_err_d    = crc_err_q;
    end_err_d    = end_err_q;
    tmo_err_d    = tmo_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_WAIT_START;
          shreg_d   = '0;
          crc_d     = '0;
          rx_crc_d  = '0;
          bit_cnt_d = '0;
          tmo_d     = '0;
          crc_err_d = 1'b0;
          end_err_d = 1'b0;
          tmo_err_d = 1'b0;
        end
      end
      S_WAIT_START: begin
        if (bus.bitEn) begin
          if (!bus.datIn) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_LIMIT) begin
              tmo_err_d    = 1'b1;
              block_done_d = 1'b1;
              state_d      = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (bus.bitEn) begin
          shreg_d   = {shreg_q[5:0], bus.datIn};
          crc_d     = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q[2:0] == 3'd7) begin
            data_out_d   = {shreg_q, bus.datIn};
            byte_valid_d = 1'b1;
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_CRC;
            bit_cnt_d = '0;
          end
        end
      end
      S_CRC: begin
        // computed CRC stays frozen while the card's CRC is shifted in
        if (bus.bitEn) begin
          rx_crc_d  = {rx_crc_q[14:0], bus.datIn};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q[3:0] == 4'hF) begin
            state_d   = S_END;
            bit_cnt_d = '0;
          end
        end
      end
      S_END: begin
        if (bus.bitEn) begin
          end_err_d    = ~bus.datIn;
          crc_err_d    = (rx_crc_q != crc_q);
          block_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dataOut      = data_out_q;
  assign bus.byteValid    = byte_valid_q;
  assign bus.blockDone    = block_done_q;
  assign bus.crcError     = crc_err_q;
  assign bus.endError     = end_err_q;
  assign bus.timeoutError = tmo_err_q;
  assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_sdc_reader_data_rx.sv
// tb/tb_sdc_reader_data_rx.sv - scoreboard bench for the SD DAT0 block receiver
module tb_sdc_reader_data_rx;
  localparam int BB  = 512;
  localparam int TMO = 40;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdc_reader_data_rx_if ifc();

  sdc_reader_data_rx #(.BLOCK_BYTES(BB), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  logic [7:0] exp_bytes[$];
  logic [2:0] exp_done[$];
  int checks = 0;
  int errors = 0;
  int spacing_max = 1;
  logic [7:0] mon_b;
  logic [2:0] mon_f;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
  function automatic logic [15:0] ref_crc(input bq_t d);
    bit bits[$];
    logic [16:0] g = 17'h11021;
    logic [15:0] r;
    foreach (d[i]) for (int k = 7; k >= 0; k--) bits.push_back(d[i][k]);
    repeat (16) bits.push_back(1'b0);
    for (int i = 0; i < bits.size() - 16; i++)
      if (bits[i]) for (int j = 0; j <= 16; j++) bits[i+j] ^= g[16-j];
    for (int j = 0; j < 16; j++) r[15-j] = bits[bits.size()-16+j];
    return r;
  endfunction

  always @(negedge clk) begin
    if (ifc.byteValid) begin
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL byte_extra got %02h expected no byte at %0t", ifc.dataOut, $time);
      end else begin
        mon_b = exp_bytes.pop_front();
        check("dataOut", ifc.dataOut, mon_b);
      end
    end
    if (ifc.blockDone) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_extra got blockDone expected none at %0t", $time);
      end else begin
        mon_f = exp_done.pop_front();
        check("done_flags", {ifc.crcError, ifc.endError, ifc.timeoutError}, mon_f);
        check("busy_at_done", ifc.busy, 1'b0);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifc.bitEn = 1'b0;
      ifc.start = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input logic st);
    int n;
    @(posedge clk); #1;
    ifc.bitEn = 1'b1;
    ifc.datIn = b;
    ifc.start = st;
    n = (spacing_max > 1) ? int'($urandom_range(spacing_max, 1)) : 1;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      ifc.bitEn = 1'b0;
      ifc.start = 1'b0;
      ifc.datIn = 1'($urandom);
    end
  endtask

  task automatic pulse_start();
    idle_cycles(1);
    @(posedge clk); #1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    check("busy_after_start", ifc.busy, 1'b1);
    check("flags_cleared_by_start", {ifc.crcError, ifc.endError, ifc.timeoutError}, 3'b000);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && exp_done.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_done.size() != 0) begin
      errors++;
      $display("FAIL done_wait got no blockDone expected blockDone within 50 cycles");
      exp_done.delete();
    end
    @(negedge clk);
    check("busy_after_done", ifc.busy, 1'b0);
    check("bytes_outstanding", exp_bytes.size(), 0);
    exp_bytes.delete();
  endtask

  task automatic send_block(input bq_t d, input logic [15:0] crc, input logic endb,
                            input int lead, input int abort_after, input int start_at);
    pulse_start();
    repeat (lead) drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    foreach (d[i]) begin
      if (abort_after >= 0 && i == abort_after) return;
      exp_bytes.push_back(d[i]);
      for (int k = 7; k >= 0; k--) drive_bit(d[i][k], (i == start_at && k == 3));
    end
    for (int k = 15; k >= 0; k--) drive_bit(crc[k], 1'b0);
    exp_done.push_back({crc != ref_crc(d), ~endb, 1'b0});
    drive_bit(endb, 1'b0);
    idle_cycles(1);
    wait_done();
  endtask

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog got no completion expected finish before 1500000 ns");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t ff, seq, rnd;
    ifc.bitEn = 1'b0;
    ifc.datIn = 1'b1;
    ifc.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dataOut", ifc.dataOut, 8'h00);
    check("rst_byteValid", ifc.byteValid, 1'b0);
    check("rst_blockDone", ifc.blockDone, 1'b0);
    check("rst_flags", {ifc.crcError, ifc.endError, ifc.timeoutError}, 3'b000);
    check("rst_busy", ifc.busy, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < BB; i++) ff.push_back(8'hFF);
    for (int r = 0; r < 2; r++) for (int i = 0; i < 256; i++) seq.push_back(8'(i));
    for (int i = 0; i < BB; i++) rnd.push_back(8'($urandom));

    send_block(ff, 16'h7FA1, 1'b1, 3, -1, -1);
    send_block(ff, 16'h7FA0, 1'b1, 3, -1, -1);
    send_block(ff, 16'h7FA1, 1'b0, 3, -1, -1);

    pulse_start();
    exp_done.push_back(3'b001);
    repeat (TMO) drive_bit(1'b1, 1'b0);
    idle_cycles(1);
    wait_done();
    check("timeout_sticky", ifc.timeoutError, 1'b1);

    send_block(ff, 16'h7FA1, 1'b1, 3, 100, -1);
    @(posedge clk); #1;
    ifc.bitEn = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {ifc.dataOut, ifc.byteValid, ifc.blockDone, ifc.crcError,
                             ifc.endError, ifc.timeoutError, ifc.busy}, 14'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_bytes_seen", exp_bytes.size(), 0);
    exp_bytes.delete();
    send_block(ff, 16'h7FA1, 1'b1, 3, -1, -1);

    spacing_max = 5;
    send_block(seq, ref_crc(seq), 1'b1, int'($urandom_range(TMO - 1, 0)), -1, 300);
    send_block(rnd, ref_crc(rnd), 1'b1, TMO - 1, -1, -1);
    spacing_max = 1;

    idle_cycles(3);
    check("final_busy", ifc.busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
